// File: rtl/instruction_fetch_decode_if.sv
// Issue bus between the fetch/decode stage and the BIP datapath.
// Handshake: the master raises instr_valid with opcode, operand and all
// controls stable; they stay unchanged until the cycle in which the slave
// also holds instr_ready high. That cycle is the transfer. The master never
// withdraws instr_valid before the transfer, except on reset.
interface instruction_fetch_decode_if #(
  parameter int bits_address = 11,
  parameter int bits_opcode  = 5
);
  logic                    instr_valid;
  logic                    instr_ready;
  logic [bits_opcode-1:0]  opcode;
  logic [bits_address-1:0] operand;
  logic [1:0]              sel_a;
  logic                    sel_b;
  logic                    wr_acc;
  logic                    alu_op;
  logic                    wr_ram;
  logic                    rd_ram;

  modport master (
    output instr_valid, opcode, operand, sel_a, sel_b, wr_acc, alu_op, wr_ram, rd_ram,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, opcode, operand, sel_a, sel_b, wr_acc, alu_op, wr_ram, rd_ram,
    output instr_ready
  );
endinterface

// File: rtl/instruction_fetch_decode.sv
// BIP instruction fetch/decode stage.
// FETCH drives the ROM address, CAPTURE latches and decodes the ROM word,
// ISSUE presents the instruction on the issue bus until accepted, HALT is
// terminal after HLT. Optional macro FETCH_ILLEGAL_TRAP_EN turns unused
// opcodes into a trap (HALT plus the sticky 'illegal' output); without it
// they execute as NOPs.
module instruction_fetch_decode #(
  parameter int bits_address = 11,
  parameter int bits_opcode  = 5
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [bits_address-1:0]             address_in,
  output logic                                pc_enable,
  output logic [bits_address-1:0]             rom_addr,
  input  logic [bits_opcode+bits_address-1:0] rom_data,
  instruction_fetch_decode_if.master          issue,
  output logic                                halted,
`ifdef FETCH_ILLEGAL_TRAP_EN
  output logic                                illegal,
`endif
  output logic [1:0]                          state_dbg
);

  localparam int instr_w = bits_opcode + bits_address;

  localparam logic [bits_opcode-1:0] op_hlt  = 'd0;
  localparam logic [bits_opcode-1:0] op_sto  = 'd1;
  localparam logic [bits_opcode-1:0] op_ld   = 'd2;
  localparam logic [bits_opcode-1:0] op_ldi  = 'd3;
  localparam logic [bits_opcode-1:0] op_add  = 'd4;
  localparam logic [bits_opcode-1:0] op_addi = 'd5;
  localparam logic [bits_opcode-1:0] op_sub  = 'd6;
  localparam logic [bits_opcode-1:0] op_subi = 'd7;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CAPTURE = 2'd1,
    ISSUE   = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t state;

  logic [bits_opcode-1:0] rom_op;
  logic [1:0]             dec_sel_a;
  logic                   dec_sel_b;
  logic                   dec_wr_acc;
  logic                   dec_alu_op;
  logic                   dec_wr_ram;
  logic                   dec_rd_ram;
  // Set when accepting this instruction should advance the PC.
  logic                   dec_advance;
  logic                   advance_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic                   dec_trap;
  logic                   trap_q;
`endif

  assign rom_addr  = address_in;
  assign rom_op    = rom_data[instr_w-1 -: bits_opcode];
  assign state_dbg = state;

  // The PC steps on the transfer edge itself, so this pulse must follow
  // instr_ready in the same cycle; everything it depends on is registered.
  assign pc_enable = issue.instr_valid & issue.instr_ready & advance_q;

  // Decode the ROM word that is being captured this cycle.
  always_comb begin
    dec_sel_a   = 2'd0;
    dec_sel_b   = 1'b0;
    dec_wr_acc  = 1'b0;
    dec_alu_op  = 1'b0;
    dec_wr_ram  = 1'b0;
    dec_rd_ram  = 1'b0;
    dec_advance = 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
    dec_trap    = 1'b0;
`endif
    case (rom_op)
      op_hlt:  dec_advance = 1'b0;
      op_sto:  dec_wr_ram = 1'b1;
      op_ld: begin
        dec_sel_a  = 2'd0;
        dec_wr_acc = 1'b1;
        dec_rd_ram = 1'b1;
      end
      op_ldi: begin
        dec_sel_a  = 2'd1;
        dec_wr_acc = 1'b1;
      end
      op_add: begin
        dec_sel_a  = 2'd2;
        dec_wr_acc = 1'b1;
        dec_rd_ram = 1'b1;
      end
      op_addi: begin
        dec_sel_a  = 2'd2;
        dec_sel_b  = 1'b1;
        dec_wr_acc = 1'b1;
      end
      op_sub: begin
        dec_sel_a  = 2'd2;
        dec_wr_acc = 1'b1;
        dec_alu_op = 1'b1;
        dec_rd_ram = 1'b1;
      end
      op_subi: begin
        dec_sel_a  = 2'd2;
        dec_sel_b  = 1'b1;
        dec_wr_acc = 1'b1;
        dec_alu_op = 1'b1;
      end
      default: begin
        // Unused opcode: issues with every control low.
`ifdef FETCH_ILLEGAL_TRAP_EN
        dec_advance = 1'b0;
        dec_trap    = 1'b1;
`endif
      end
    endcase
  end

  // Stage FSM with registered issue-bus outputs; controls are only non-zero
  // while instr_valid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= FETCH;
      issue.instr_valid <= 1'b0;
      issue.opcode      <= '0;
      issue.operand     <= '0;
      issue.sel_a       <= 2'd0;
      issue.sel_b       <= 1'b0;
      issue.wr_acc      <= 1'b0;
      issue.alu_op      <= 1'b0;
      issue.wr_ram      <= 1'b0;
      issue.rd_ram      <= 1'b0;
      advance_q         <= 1'b0;
      halted            <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      trap_q            <= 1'b0;
      illegal           <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          issue.instr_valid <= 1'b1;
          issue.opcode      <= rom_op;
          issue.operand     <= rom_data[bits_address-1:0];
          issue.sel_a       <= dec_sel_a;
          issue.sel_b       <= dec_sel_b;
          issue.wr_acc      <= dec_wr_acc;
          issue.alu_op      <= dec_alu_op;
          issue.wr_ram      <= dec_wr_ram;
          issue.rd_ram      <= dec_rd_ram;
          advance_q         <= dec_advance;
`ifdef FETCH_ILLEGAL_TRAP_EN
          trap_q            <= dec_trap;
`endif
          state             <= ISSUE;
        end
        ISSUE: begin
          if (issue.instr_ready) begin
            issue.instr_valid <= 1'b0;
            issue.sel_a       <= 2'd0;
            issue.sel_b       <= 1'b0;
            issue.wr_acc      <= 1'b0;
            issue.alu_op      <= 1'b0;
            issue.wr_ram      <= 1'b0;
            issue.rd_ram      <= 1'b0;
            advance_q         <= 1'b0;
            if (advance_q) begin
              state <= FETCH;
            end else begin
              state  <= HALT;
              halted <= 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
              illegal <= trap_q;
`endif
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
